// File: rtl/cond_logic_ex.sv
// cond_logic_ex: execute-stage conditional-logic unit of the pipelined ARMv4 core.
// It owns the NZCV flags register. It evaluates the condition field against the
// registered flags, gates the PC/register/memory write enables by the result, and
// registers them into the E->M pipeline boundary.
// Optional build macro: COND_STATS_EN adds the CondPassCount and CondFailCount
// statistics counters.
module cond_logic_ex #(
  parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        StallE,
  input  logic        FlushE,
  input  logic        ValidE,
  input  logic [3:0]  CondE,
  input  logic [3:0]  ALUFlags,
  input  logic [1:0]  FlagWriteE,
  input  logic        PCSrcE,
  input  logic        RegWriteE,
  input  logic        MemWriteE,
  output logic [3:0]  Flags,
  output logic        CondExE,
  output logic        BranchTakenE,
  output logic        PCSrcM,
  output logic        RegWriteM,
  output logic        MemWriteM,
  output logic        ValidM
`ifdef COND_STATS_EN
  ,
  output logic [31:0] CondPassCount,
  output logic [31:0] CondFailCount
`endif
);

  // ARM condition-code decode against a stored NZCV value; 1111 never passes.
  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v, ge;
    n  = nzcv[3];
    z  = nzcv[2];
    c  = nzcv[1];
    v  = nzcv[0];
    ge = (n == v);
    case (cond)
      4'b0000: cond_pass = z;
      4'b0001: cond_pass = ~z;
      4'b0010: cond_pass = c;
      4'b0011: cond_pass = ~c;
      4'b0100: cond_pass = n;
      4'b0101: cond_pass = ~n;
      4'b0110: cond_pass = v;
      4'b0111: cond_pass = ~v;
      4'b1000: cond_pass = c & ~z;
      4'b1001: cond_pass = ~(c & ~z);
      4'b1010: cond_pass = ge;
      4'b1011: cond_pass = ~ge;
      4'b1100: cond_pass = ~z & ge;
      4'b1101: cond_pass = ~(~z & ge);
      4'b1110: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  endfunction

  logic advance_e;
  logic commit_e;
  logic fail_e;

  // Condition evaluation uses only the registered flags: there is no ALUFlags
  // forwarding, so a flag update becomes visible to the next instruction.
  always_comb begin
    CondExE      = cond_pass(CondE, Flags);
    BranchTakenE = PCSrcE & CondExE & ValidE & ~FlushE;
    advance_e    = ValidE & ~FlushE & ~StallE;
    commit_e     = advance_e & CondExE;
    fail_e       = advance_e & ~CondExE;
  end

  // NZCV register: N,Z and C,V pairs load independently on a committed write.
  always_ff @(posedge clk) begin
    if (reset) begin
      Flags <= RESET_FLAGS;
    end else if (commit_e) begin
      if (FlagWriteE[1]) Flags[3:2] <= ALUFlags[3:2];
      if (FlagWriteE[0]) Flags[1:0] <= ALUFlags[1:0];
    end
  end

  // ---- E -> M boundary: reset > flush > stall > normal advance ----
  // E->M register; a condition-failed instruction still advances as valid with its writes killed.
  always_ff @(posedge clk) begin
    if (reset) begin
      PCSrcM    <= 1'b0;
      RegWriteM <= 1'b0;
      MemWriteM <= 1'b0;
      ValidM    <= 1'b0;
    end else if (FlushE) begin
      PCSrcM    <= 1'b0;
      RegWriteM <= 1'b0;
      MemWriteM <= 1'b0;
      ValidM    <= 1'b0;
    end else if (!StallE) begin
      PCSrcM    <= PCSrcE    & ValidE & CondExE;
      RegWriteM <= RegWriteE & ValidE & CondExE;
      MemWriteM <= MemWriteE & ValidE & CondExE;
      ValidM    <= ValidE;
    end
  end

`ifdef COND_STATS_EN
  // Pass/fail statistics; both counters wrap naturally at 32 bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      CondPassCount <= 32'd0;
      CondFailCount <= 32'd0;
    end else begin
      if (commit_e) CondPassCount <= CondPassCount + 32'd1;
      if (fail_e)   CondFailCount <= CondFailCount + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cond_logic_ex.sv
// Testbench for cond_logic_ex: a table of per-cycle vectors with expected
// combinational and registered results, plus a condition-code sweep and an
// optional statistics-counter sequence.
module tb_cond_logic_ex;

  logic        clk = 1'b0;
  logic        reset, StallE, FlushE, ValidE;
  logic [3:0]  CondE, ALUFlags;
  logic [1:0]  FlagWriteE;
  logic        PCSrcE, RegWriteE, MemWriteE;
  logic [3:0]  Flags;
  logic        CondExE, BranchTakenE, PCSrcM, RegWriteM, MemWriteM, ValidM;
`ifdef COND_STATS_EN
  logic [31:0] CondPassCount, CondFailCount;
`endif

  always #5 clk = ~clk;

  cond_logic_ex #(.RESET_FLAGS(4'b0000)) dut (
    .clk(clk), .reset(reset), .StallE(StallE), .FlushE(FlushE), .ValidE(ValidE),
    .CondE(CondE), .ALUFlags(ALUFlags), .FlagWriteE(FlagWriteE),
    .PCSrcE(PCSrcE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
    .Flags(Flags), .CondExE(CondExE), .BranchTakenE(BranchTakenE),
    .PCSrcM(PCSrcM), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ValidM(ValidM)
`ifdef COND_STATS_EN
    , .CondPassCount(CondPassCount), .CondFailCount(CondFailCount)
`endif
  );

  typedef struct {
    string      name;
    logic       rst, stall, flush, valid;
    logic [3:0] cond, alu;
    logic [1:0] fw;
    logic       pcs, rw, mw;
    logic       x_cex, x_bt;
    logic [3:0] x_flags;
    logic       x_pcm, x_rwm, x_mwm, x_vm;
  } vec_t;

  typedef struct {
    string      name;
    logic [3:0] flags;
    logic       pcm, rwm, mwm, vm;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string name,
                              input logic rst, input logic stall, input logic flush, input logic valid,
                              input logic [3:0] cond, input logic [1:0] fw, input logic [3:0] alu,
                              input logic pcs, input logic rw, input logic mw,
                              input logic x_cex, input logic x_bt, input logic [3:0] x_flags,
                              input logic x_pcm, input logic x_rwm, input logic x_mwm, input logic x_vm);
    vec_t v;
    v.name = name; v.rst = rst; v.stall = stall; v.flush = flush; v.valid = valid;
    v.cond = cond; v.fw = fw; v.alu = alu; v.pcs = pcs; v.rw = rw; v.mw = mw;
    v.x_cex = x_cex; v.x_bt = x_bt; v.x_flags = x_flags;
    v.x_pcm = x_pcm; v.x_rwm = x_rwm; v.x_mwm = x_mwm; v.x_vm = x_vm;
    return v;
  endfunction

  // Condition table written straight from the ARM condition-code list.
  function automatic logic cond_ref(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'h0: return z;          4'h1: return !z;
      4'h2: return cy;         4'h3: return !cy;
      4'h4: return n;          4'h5: return !n;
      4'h6: return v;          4'h7: return !v;
      4'h8: return cy && !z;   4'h9: return !cy || z;
      4'hA: return n == v;     4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic apply(input vec_t v);
    exp_t e;
    @(negedge clk);
    reset = v.rst; StallE = v.stall; FlushE = v.flush; ValidE = v.valid;
    CondE = v.cond; FlagWriteE = v.fw; ALUFlags = v.alu;
    PCSrcE = v.pcs; RegWriteE = v.rw; MemWriteE = v.mw;
    #1;
    chk({v.name, ".CondExE"}, CondExE, v.x_cex);
    chk({v.name, ".BranchTakenE"}, BranchTakenE, v.x_bt);
    e.name = v.name; e.flags = v.x_flags;
    e.pcm = v.x_pcm; e.rwm = v.x_rwm; e.mwm = v.x_mwm; e.vm = v.x_vm;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({e.name, ".Flags"}, Flags, e.flags);
      chk({e.name, ".PCSrcM"}, PCSrcM, e.pcm);
      chk({e.name, ".RegWriteM"}, RegWriteM, e.rwm);
      chk({e.name, ".MemWriteM"}, MemWriteM, e.mwm);
      chk({e.name, ".ValidM"}, ValidM, e.vm);
    end
  endtask

  initial begin
    logic [3:0] fvals [5];
    reset = 1'b1; StallE = 1'b0; FlushE = 1'b0; ValidE = 1'b0;
    CondE = 4'hE; ALUFlags = 4'h0; FlagWriteE = 2'b00;
    PCSrcE = 1'b0; RegWriteE = 1'b0; MemWriteE = 1'b0;
    repeat (2) @(posedge clk);

    //            name          rst st fl va cond   fw     alu    pc rw mw  cex bt flags  pcm rwm mwm vm
    vecs.push_back(mk("reset",      1, 0, 0, 0, 4'hE, 2'b00, 4'h0, 0, 0, 0,  1, 0, 4'h0, 0, 0, 0, 0));
    vecs.push_back(mk("idle_al",    0, 0, 0, 0, 4'hE, 2'b00, 4'h0, 0, 0, 0,  1, 0, 4'h0, 0, 0, 0, 0));
    vecs.push_back(mk("idle_nv",    0, 0, 0, 0, 4'hF, 2'b00, 4'h0, 0, 0, 0,  0, 0, 4'h0, 0, 0, 0, 0));
    vecs.push_back(mk("al_setz",    0, 0, 0, 1, 4'hE, 2'b11, 4'h4, 0, 0, 0,  1, 0, 4'h4, 0, 0, 0, 1));
    vecs.push_back(mk("eq_rw",      0, 0, 0, 1, 4'h0, 2'b00, 4'h0, 0, 1, 0,  1, 0, 4'h4, 0, 1, 0, 1));
    vecs.push_back(mk("ne_mw_fail", 0, 0, 0, 1, 4'h1, 2'b11, 4'h9, 0, 0, 1,  0, 0, 4'h4, 0, 0, 0, 1));
    vecs.push_back(mk("al_set_all", 0, 0, 0, 1, 4'hE, 2'b11, 4'hF, 0, 0, 0,  1, 0, 4'hF, 0, 0, 0, 1));
    vecs.push_back(mk("al_part_nz", 0, 0, 0, 1, 4'hE, 2'b10, 4'h0, 0, 0, 0,  1, 0, 4'h3, 0, 0, 0, 1));
    vecs.push_back(mk("ge_fail",    0, 0, 0, 1, 4'hA, 2'b00, 4'h0, 0, 1, 0,  0, 0, 4'h3, 0, 0, 0, 1));
    vecs.push_back(mk("lt_branch",  0, 0, 0, 1, 4'hB, 2'b00, 4'h0, 1, 1, 0,  1, 1, 4'h3, 1, 1, 0, 1));
    vecs.push_back(mk("hi_mw",      0, 0, 0, 1, 4'h8, 2'b00, 4'h0, 0, 0, 1,  1, 0, 4'h3, 0, 0, 1, 1));
    vecs.push_back(mk("stall1",     0, 1, 0, 1, 4'hE, 2'b11, 4'hF, 1, 0, 0,  1, 1, 4'h3, 0, 0, 1, 1));
    vecs.push_back(mk("stall2",     0, 1, 0, 1, 4'hE, 2'b11, 4'hF, 1, 0, 0,  1, 1, 4'h3, 0, 0, 1, 1));
    vecs.push_back(mk("stall3",     0, 1, 0, 1, 4'hE, 2'b11, 4'hF, 1, 0, 0,  1, 1, 4'h3, 0, 0, 1, 1));
    vecs.push_back(mk("unstall",    0, 0, 0, 1, 4'hE, 2'b11, 4'hF, 1, 0, 0,  1, 1, 4'hF, 1, 0, 0, 1));
    vecs.push_back(mk("flush_stall",0, 1, 1, 1, 4'hE, 2'b11, 4'h0, 1, 0, 0,  1, 0, 4'hF, 0, 0, 0, 0));
    vecs.push_back(mk("gt_fail",    0, 0, 0, 1, 4'hC, 2'b00, 4'h0, 0, 1, 0,  0, 0, 4'hF, 0, 0, 0, 1));
    vecs.push_back(mk("le_all",     0, 0, 0, 1, 4'hD, 2'b00, 4'h0, 1, 1, 1,  1, 1, 4'hF, 1, 1, 1, 1));
    vecs.push_back(mk("reset_mid",  1, 1, 0, 1, 4'hE, 2'b11, 4'h0, 1, 1, 0,  1, 1, 4'h0, 0, 0, 0, 0));
    vecs.push_back(mk("flush_only", 0, 0, 1, 1, 4'hE, 2'b11, 4'hA, 0, 1, 0,  1, 0, 4'h0, 0, 0, 0, 0));
    vecs.push_back(mk("invalid",    0, 0, 0, 0, 4'hE, 2'b11, 4'hF, 1, 1, 0,  1, 0, 4'h0, 0, 0, 0, 0));
    vecs.push_back(mk("nv_valid",   0, 0, 0, 1, 4'hF, 2'b11, 4'hF, 0, 1, 0,  0, 0, 4'h0, 0, 0, 0, 1));
    vecs.push_back(mk("vs_fail",    0, 0, 0, 1, 4'h6, 2'b00, 4'h0, 0, 0, 1,  0, 0, 4'h0, 0, 0, 0, 1));
    vecs.push_back(mk("cc_rw",      0, 0, 0, 1, 4'h3, 2'b00, 4'h0, 0, 1, 0,  1, 0, 4'h0, 0, 1, 0, 1));

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

    // Condition-code sweep over several flag patterns loaded by AL instructions.
    fvals[0] = 4'b0000; fvals[1] = 4'b0101; fvals[2] = 4'b1010;
    fvals[3] = 4'b0110; fvals[4] = 4'b1001;
    for (int k = 0; k < 5; k++) begin
      apply(mk("load_flags", 0, 0, 0, 1, 4'hE, 2'b11, fvals[k], 0, 0, 0, 1, 0, fvals[k], 0, 0, 0, 1));
      for (int c = 0; c < 16; c++) begin
        @(negedge clk);
        ValidE = 1'b0; CondE = 4'(c); FlagWriteE = 2'b00;
        #1;
        chk($sformatf("sweep_f%0h_c%0h", fvals[k], c), CondExE, cond_ref(4'(c), fvals[k]));
      end
    end

`ifdef COND_STATS_EN
    // Three passes, two fails; a stalled pass and a flushed fail must not count.
    @(negedge clk);
    reset = 1'b1; StallE = 1'b0; FlushE = 1'b0; ValidE = 1'b0; FlagWriteE = 2'b00;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("stats_reset_pass", CondPassCount, 32'd0);
    chk("stats_reset_fail", CondFailCount, 32'd0);
    for (int j = 0; j < 7; j++) begin
      ValidE = 1'b1;
      StallE = (j == 5);
      FlushE = (j == 6);
      CondE  = (j == 1 || j == 3 || j == 6) ? 4'hF : 4'hE;
      @(negedge clk);
    end
    ValidE = 1'b0; StallE = 1'b0; FlushE = 1'b0;
    @(negedge clk);
    chk("stats_pass", CondPassCount, 32'd3);
    chk("stats_fail", CondFailCount, 32'd2);
`endif

    chk("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
